// File: rtl/rf_param_clr.sv
// rf_param_clr -- parametrised decode-stage register file with hardware clear.
//
// Two combinational read ports (rs -> rfa, rt -> rfb) and a debug read port
// (dbg_addr -> dbg_data). There is one write port, whose destination is rd, rt,
// RA_ADDR or none (c_wb_dest). The write can be conditional on the stored rt
// value: always, MOVZ, MOVN or never. Register 0 and any address >= RF_SIZE
// read as zero and are never written.
//
// After reset the file clears registers 1..RF_SIZE-1, one per clock. rf_ready
// then rises. Until it does, all reads return 0 and writes are dropped.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst_n      synchronous active-low reset (restarts the clear sequence)
//   c_rf_we    write request
//   c_wb_dest  00 rd, 01 rt, 10 RA_ADDR, 11 none
//   c_cond     00 always, 01 MOVZ, 10 MOVN, 11 never
//   rs, rt, rd read A / read B + condition operand / destination addresses
//   wb_data    write data
//   dbg_addr   debug read address
//   rfa, rfb, dbg_data  read data
//   rf_ready   clear sequence complete
module rf_param_clr #(
   parameter int W_DATA   = 32,
   parameter int W_RFADDR = 5,
   parameter int RF_SIZE  = 32,
   parameter int RA_ADDR  = 31,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                c_rf_we,
   input  logic [1:0]          c_wb_dest,
   input  logic [1:0]          c_cond,
   input  logic [W_RFADDR-1:0] rs,
   input  logic [W_RFADDR-1:0] rt,
   input  logic [W_RFADDR-1:0] rd,
   input  logic [W_DATA-1:0]   wb_data,
   input  logic [W_RFADDR-1:0] dbg_addr,
   output logic [W_DATA-1:0]   rfa,
   output logic [W_DATA-1:0]   rfb,
   output logic [W_DATA-1:0]   dbg_data,
   output logic                rf_ready
);

   localparam logic [W_RFADDR-1:0] RA_A = W_RFADDR'(RA_ADDR);
   localparam logic [W_RFADDR-1:0] LAST = W_RFADDR'(RF_SIZE - 1);
   // RF_SIZE may equal 2^W_RFADDR, so the range compare uses one extra bit.
   localparam logic [W_RFADDR:0]   SIZE = (W_RFADDR + 1)'(RF_SIZE);

   typedef enum logic {S_CLEAR, S_RUN} state_e;

   state_e              state_q, state_d;
   logic [W_RFADDR-1:0] clr_cnt_q, clr_cnt_d;
   logic                rdy_q, rdy_d;
   logic                clr_we;

   // No storage is allocated for register 0.
   logic [W_DATA-1:0]   mem_q [1:RF_SIZE-1];

   logic [W_RFADDR-1:0] wr;
   logic                cond_ok, we, z;
   logic [W_DATA-1:0]   rs_st, rt_st, dbg_st;

   function automatic logic in_rng(input logic [W_RFADDR-1:0] a);
      return (a != '0) && ({1'b0, a} < SIZE);
   endfunction

   // Read mux: gated while clearing, optionally forwards the write in flight.
   function automatic logic [W_DATA-1:0] rd_mux(
      input logic                rdy,
      input logic                wen,
      input logic [W_RFADDR-1:0] addr,
      input logic [W_RFADDR-1:0] waddr,
      input logic [W_DATA-1:0]   wdata,
      input logic [W_DATA-1:0]   st
   );
      if (!rdy)                                  return '0;
      if ((BYPASS != 0) && wen && addr == waddr) return wdata;
      return st;
   endfunction

   assign rs_st  = in_rng(rs)       ? mem_q[rs]       : '0;
   assign rt_st  = in_rng(rt)       ? mem_q[rt]       : '0;
   assign dbg_st = in_rng(dbg_addr) ? mem_q[dbg_addr] : '0;

   // The condition looks at the stored rt value only. Using the bypassed
   // value would feed the write enable back into itself.
   assign z = (rt_st == '0);

   always_comb begin
      wr      = '0;
      cond_ok = 1'b0;
      case (c_wb_dest)
         2'b00:   wr = rd;
         2'b01:   wr = rt;
         2'b10:   wr = RA_A;
         default: wr = '0;
      endcase
      case (c_cond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = z;
         2'b10:   cond_ok = ~z;
         default: cond_ok = 1'b0;
      endcase
   end

   // in_rng() also rejects wr == 0 and out-of-range destinations.
   assign we = rdy_q & c_rf_we & cond_ok & in_rng(wr);

   assign rfa      = rd_mux(rdy_q, we, rs,       wr, wb_data, rs_st);
   assign rfb      = rd_mux(rdy_q, we, rt,       wr, wb_data, rt_st);
   assign dbg_data = rd_mux(rdy_q, we, dbg_addr, wr, wb_data, dbg_st);
   assign rf_ready = rdy_q;

   // Clear sequencer: clr_cnt walks 1..RF_SIZE-1, one register per clock.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      rdy_d     = rdy_q;
      clr_we    = 1'b0;
      if (state_q == S_CLEAR) begin
         clr_we    = 1'b1;
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == LAST) begin
            state_d = S_RUN;
            rdy_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= W_RFADDR'(1);
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rdy_q     <= rdy_d;
      end
   end

   // Reset blocks every array write. Functional writes only happen once
   // rdy_q is set, so they never collide with clearing.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we)  mem_q[clr_cnt_q] <= '0;
         else if (we) mem_q[wr]        <= wb_data;
      end
   end

endmodule

// File: tb/tb_rf_param_clr.sv
module tb_rf_param_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, c_rf_we;
   logic [1:0]  c_wb_dest, c_cond;
   logic [4:0]  rs, rt, rd, dbg_addr;
   logic [31:0] wb_data;
   logic [31:0] rfa1, rfb1, dbg1, rfa0, rfb0, dbg0;
   logic        rdy1, rdy0;

   // Instance 0 of the model is the default build. Instance 1 of the model is a
   // smaller file with no bypass, so it can show out-of-range addresses.
   rf_param_clr u_main (
      .clk(clk), .rst_n(rst_n), .c_rf_we(c_rf_we), .c_wb_dest(c_wb_dest),
      .c_cond(c_cond), .rs(rs), .rt(rt), .rd(rd), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .rfa(rfa1), .rfb(rfb1), .dbg_data(dbg1),
      .rf_ready(rdy1));

   rf_param_clr #(.RF_SIZE(24), .RA_ADDR(23), .BYPASS(0)) u_small (
      .clk(clk), .rst_n(rst_n), .c_rf_we(c_rf_we), .c_wb_dest(c_wb_dest),
      .c_cond(c_cond), .rs(rs), .rt(rt), .rd(rd), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .rfa(rfa0), .rfb(rfb0), .dbg_data(dbg0),
      .rf_ready(rdy0));

   int nvec = 0;
   int nerr = 0;

   // Reference model: the register contents as a plain array, plus a
   // countdown of the clear cycles still to run.
   logic [31:0] m [2][32];
   bit          mrdy [2];
   int          mclr [2];
   int          SZ  [2] = '{32, 24};
   int          RA  [2] = '{31, 23};
   bit          BYP [2] = '{1'b1, 1'b0};

   function automatic int wr_of(int k);
      case (c_wb_dest)
         2'd0:    return int'(rd);
         2'd1:    return int'(rt);
         2'd2:    return RA[k];
         default: return 0;
      endcase
   endfunction

   function automatic bit valid(int k, int a);
      return a != 0 && a < SZ[k];
   endfunction

   function automatic logic [31:0] st(int k, int a);
      return valid(k, a) ? m[k][a] : 32'h0;
   endfunction

   function automatic bit we_of(int k);
      bit z, ok;
      z = (st(k, int'(rt)) == 32'h0);
      ok = (c_cond == 2'd0) || (c_cond == 2'd1 && z) || (c_cond == 2'd2 && !z);
      return mrdy[k] && c_rf_we && ok && valid(k, wr_of(k));
   endfunction

   function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
      if (!mrdy[k]) return 32'h0;
      if (BYP[k] && we_of(k) && int'(a) == wr_of(k)) return wb_data;
      return st(k, int'(a));
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_all();
      chk("main rf_ready", {31'h0, rdy1}, {31'h0, mrdy[0]});
      chk("main rfa", rfa1, exp_rd(0, rs));
      chk("main rfb", rfb1, exp_rd(0, rt));
      chk("main dbg", dbg1, exp_rd(0, dbg_addr));
      chk("small rf_ready", {31'h0, rdy0}, {31'h0, mrdy[1]});
      chk("small rfa", rfa0, exp_rd(1, rs));
      chk("small rfb", rfb0, exp_rd(1, rt));
      chk("small dbg", dbg0, exp_rd(1, dbg_addr));
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            mrdy[k] = 1'b0;
            mclr[k] = SZ[k] - 1;
         end else if (!mrdy[k]) begin
            mclr[k]--;
            if (mclr[k] == 0) begin
               mrdy[k] = 1'b1;
               for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
            end
         end else if (we_of(k)) begin
            m[k][wr_of(k)] = wb_data;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Release reset and measure how many posedges pass before each file is ready.
   task automatic count_ready();
      logic [31:0] n1, n0;
      n1 = 32'hFFFF_FFFF;
      n0 = 32'hFFFF_FFFF;
      rst_n   = 1'b1;
      c_rf_we = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (rdy1 && n1 == 32'hFFFF_FFFF) n1 = 32'(i);
         if (rdy0 && n0 == 32'hFFFF_FFFF) n0 = 32'(i);
      end
      chk("clear cycles main", n1, 32'd31);
      chk("clear cycles small", n0, 32'd23);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  dest, cond;
      logic [4:0]  rs, rt, rd;
      logic [31:0] wb, ea, eb;
   } vec_t;

   function automatic vec_t mk(logic we, logic [1:0] dest, logic [1:0] cond,
                               logic [4:0] a, logic [4:0] b, logic [4:0] d,
                               logic [31:0] wb, logic [31:0] ea, logic [31:0] eb);
      vec_t v;
      v.we = we; v.dest = dest; v.cond = cond; v.rs = a; v.rt = b; v.rd = d;
      v.wb = wb; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   vec_t tv [16];

   initial begin
      // Expected rfa/rfb of the default build. The file is all zero at the start.
      tv[0]  = mk(1, 0, 0,  5, 0, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
      tv[1]  = mk(0, 0, 0,  5, 5, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
      tv[2]  = mk(1, 0, 0,  0, 0, 0, 32'h1234,     32'h0,        32'h0);
      tv[3]  = mk(1, 0, 0,  7, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
      tv[4]  = mk(0, 0, 0,  7, 3, 0, 32'h0,        32'hA5A5A5A5, 32'h0);
      tv[5]  = mk(1, 0, 1,  4, 3, 4, 32'h11,       32'h11,       32'h0);
      tv[6]  = mk(1, 0, 0,  4, 0, 3, 32'h9,        32'h11,       32'h0);
      tv[7]  = mk(1, 0, 1,  4, 3, 4, 32'h55,       32'h11,       32'h9);
      tv[8]  = mk(1, 0, 2,  4, 3, 4, 32'h66,       32'h66,       32'h9);
      tv[9]  = mk(1, 0, 3,  4, 3, 4, 32'h77,       32'h66,       32'h9);
      tv[10] = mk(1, 0, 0,  3, 0, 3, 32'h0,        32'h0,        32'h0);
      tv[11] = mk(1, 0, 1,  3, 3, 3, 32'h22,       32'h22,       32'h22);
      tv[12] = mk(1, 2, 0, 31, 0, 0, 32'h400,      32'h400,      32'h0);
      tv[13] = mk(1, 1, 0,  9, 9, 0, 32'h99,       32'h99,       32'h99);
      tv[14] = mk(1, 3, 0,  0, 4, 0, 32'hBAD,      32'h0,        32'h66);
      tv[15] = mk(0, 0, 0, 31, 3, 0, 32'h0,        32'h400,      32'h22);

      rst_n = 1'b0; c_rf_we = 1'b0; c_wb_dest = 2'd0; c_cond = 2'd0;
      rs = '0; rt = '0; rd = '0; dbg_addr = '0; wb_data = '0;
      mrdy = '{1'b0, 1'b0};
      mclr = '{31, 23};

      // Clear sequence: three cycles of reset, then count to ready.
      repeat (3) cyc();
      count_ready();

      // Every register reads zero once the clear has finished.
      for (int a = 1; a < 32; a++) begin
         dbg_addr = 5'(a);
         cyc();
      end

      // Directed table.
      for (int i = 0; i < 16; i++) begin
         c_rf_we = tv[i].we; c_wb_dest = tv[i].dest; c_cond = tv[i].cond;
         rs = tv[i].rs; rt = tv[i].rt; rd = tv[i].rd; wb_data = tv[i].wb;
         dbg_addr = tv[i].rs;
         @(negedge clk);
         chk($sformatf("tv%0d rfa", i), rfa1, tv[i].ea);
         chk($sformatf("tv%0d rfb", i), rfb1, tv[i].eb);
         check_all();
         @(posedge clk);
         model_step();
         #1;
      end

      // Reset during operation, and again partway through the clear. Each
      // reset cycle also carries a write, and that write must be dropped.
      c_wb_dest = 2'd0; c_cond = 2'd0;
      c_rf_we = 1'b1; rd = 5'd5; wb_data = 32'hFF; rs = 5'd5;
      cyc();
      rst_n = 1'b0; wb_data = 32'hEE;
      cyc();
      rst_n = 1'b1; c_rf_we = 1'b0;
      repeat (10) cyc();
      rst_n = 1'b0; c_rf_we = 1'b1; wb_data = 32'hEE;
      cyc();
      count_ready();
      rs = 5'd5; dbg_addr = 5'd5; c_rf_we = 1'b0;
      @(negedge clk);
      chk("post-reset rf5 main", rfa1, 32'h0);
      chk("post-reset rf5 small", rfa0, 32'h0);
      @(posedge clk);
      model_step();
      #1;

      // Random traffic against the model, with an occasional reset.
      for (int i = 0; i < 600; i++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         c_rf_we   = ($urandom_range(0, 3) != 0);
         c_wb_dest = 2'($urandom_range(0, 3));
         c_cond    = 2'($urandom_range(0, 3));
         rs        = 5'($urandom_range(0, 31));
         rt        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7))
                                                 : 5'($urandom_range(0, 31));
         rd        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7))
                                                 : 5'($urandom_range(0, 31));
         dbg_addr  = 5'($urandom_range(0, 31));
         wb_data   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/rf_param_clr.md
Name: rf_param_clr

Overview:
- Parametrised successor to the CPU register file: same rs/rt read, write-destination mux, zero-register and conditional-write semantics.
- Generalised in data width and register count.
- Writes on the rising edge with an optional same-cycle write-to-read bypass.
- Adds MOVN and "never" conditional modes, a debug read port, and a reset-triggered hardware clear sequencer with a ready flag.
- Sits in the decode stage between instruction decode and writeback.

Parameters:
- W_DATA, 32, data width in bits.
- W_RFADDR, 5, register address width.
- RF_SIZE, 32, number of registers. Must satisfy 2 <= RF_SIZE <= 2^W_RFADDR. Register 0 is hardwired zero.
- RA_ADDR, 31, link register written when c_wb_dest selects RA. Must be < RF_SIZE.
- BYPASS, 1, 1 = same-cycle write data forwarded to rfa/rfb/dbg_data. 0 = read returns stored value.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- c_rf_we  in  1  write request.
- c_wb_dest  in  2  write destination: 00 = rd, 01 = rt, 10 = RA_ADDR, 11 = none (register 0).
- c_cond  in  2  write condition: 00 = always, 01 = MOVZ (stored rt == 0), 10 = MOVN (stored rt != 0), 11 = never.
- rs  in  W_RFADDR  read address A.
- rt  in  W_RFADDR  read address B; also the condition operand.
- rd  in  W_RFADDR  destination address.
- wb_data  in  W_DATA  write data.
- dbg_addr  in  W_RFADDR  debug read address.
- rfa  out  W_DATA  read data A.
- rfb  out  W_DATA  read data B.
- dbg_data  out  W_DATA  debug read data.
- rf_ready  out  1  1 = clear sequence done, file operational.

Behaviour:
- State machine: CLEAR, RUN.
  - While rst_n = 0 at a posedge: state <= CLEAR, clr_cnt <= 1, rf_ready <= 0. No array writes during reset.
  - CLEAR, rst_n = 1: each posedge writes 0 to rf[clr_cnt] and increments clr_cnt.
  - On the posedge that clears rf[RF_SIZE-1]: state <= RUN, rf_ready <= 1.
  - rf_ready therefore rises after exactly RF_SIZE-1 posedges with rst_n high (31 by default).
  - Reset asserted mid-CLEAR or in RUN restarts the sequence from clr_cnt = 1.
- While rf_ready = 0:
  - rfa, rfb, dbg_data are 0.
  - All functional writes are ignored; c_rf_we is don't-care.
- Reset values: rf_ready = 0, rfa = rfb = dbg_data = 0. Array contents are undefined until cleared.
- Destination wr:
  - Selected by c_wb_dest.
  - Any address >= RF_SIZE is treated as register 0 (write discarded; reads return 0).
- Condition operand: z = (stored rf[rt] == 0), with register 0 reading as 0.
  - Uses the stored value, never the bypassed value (no combinational loop).
- Write enable: we = rf_ready & c_rf_we & cond_ok & (wr != 0), where cond_ok is:
  - 1 for c_cond = 00,
  - z for 01,
  - ~z for 10,
  - 0 for 11.
- When we = 1: rf[wr] <= wb_data at posedge (one-cycle write latency).
- Reads are combinational.
  - Address 0 or an address >= RF_SIZE returns 0.
  - BYPASS = 1 and we = 1 and address == wr: returns wb_data. Applies independently to rs, rt and dbg_addr.
  - BYPASS = 0: returns the stored value; new data is visible the cycle after the write edge.
- Simultaneous cases:
  - rs == rt == wr: both ports bypass.
  - rd == rt under MOVZ: the condition uses the old rt value.
  - Reset wins over any write in the same cycle.
- Register 0 is never stored; no storage is allocated for index 0.

Test Plan:
- Clear sequence: hold rst_n = 0 for 3 cycles, release -> rf_ready = 0 for exactly 31 posedges, then 1; dbg_data = 0 for addresses 1..31.
- Basic write/read: write 0xDEADBEEF to rd = 5 with c_wb_dest = 00, c_cond = 00 -> next cycle rs = 5 gives rfa = 0xDEADBEEF. Write 0x1234 to rd = 0 -> rs = 0 gives rfa = 0.
- Bypass: BYPASS = 1, write 0xA5A5A5A5 to rd = 7 with rs = rt = 7 -> same cycle rfa = rfb = 0xA5A5A5A5. With BYPASS = 0 -> old value same cycle, new value next cycle.
- Conditional writes:
  - rf[3] = 0, MOVZ rt = 3, rd = 4, data 0x11 -> rf[4] = 0x11.
  - rf[3] = 0x9, MOVZ -> rf[4] unchanged.
  - MOVN with rf[3] = 0x9 -> rf[4] written.
  - c_cond = 11 -> no write.
  - rd = rt = 3, MOVZ, rf[3] = 0, data 0x22 -> rf[3] = 0x22.
- Destination mux: c_wb_dest = 10, data 0x400 -> rf[31] = 0x400. c_wb_dest = 01, rt = 9 -> rf[9] written. c_wb_dest = 11 -> no register changes.
- Reset mid-operation: rf[5] = 0xFF, assert rst_n = 0 at clear step 10 and issue a write in the same cycle -> write ignored, sequence restarts, rf_ready returns 31 cycles after release, rf[5] reads 0.
